rf_write_buffer: RTL

RF_WRITE_BUFFER -- requirements
Module: rf_write_buffer

---
 rtl/rf_pkg.sv | 11 +
 rtl/rf_wb_fifo.sv | 80 ++++++++
 rtl/rf_write_buffer.sv | 115 +++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared constants and write-request type for the register-file write buffer
package rf_pkg;
  localparam int RF_ADDR_W   = 3;
  localparam int RF_DATA_W   = 32;
  localparam int RF_WB_DEPTH = 4;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } rf_wreq_t;
endpackage

// File: rtl/rf_wb_fifo.sv
// rtl/rf_wb_fifo.sv - pending-write storage, pointers and occupancy count
// Extra storage/pointer ports exist only when RF_WB_FORWARD_EN is defined.
module rf_wb_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH  = RF_WB_DEPTH,
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push_i,
  input  logic                        pop_i,
  input  logic                        flush_i,
  input  logic [ADDR_W-1:0]           push_addr_i,
  input  logic [DATA_W-1:0]           push_data_i,
  output logic [ADDR_W-1:0]           head_addr_o,
  output logic [DATA_W-1:0]           head_data_o,
  output logic [$clog2(DEPTH):0]      count_o
`ifdef RF_WB_FORWARD_EN
  ,
  output logic [DEPTH-1:0][ADDR_W-1:0] mem_addr_o,
  output logic [DEPTH-1:0][DATA_W-1:0] mem_data_o,
  output logic [$clog2(DEPTH)-1:0]     rd_ptr_o
`endif
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0][ADDR_W-1:0] mem_addr_q;
  logic [DEPTH-1:0][DATA_W-1:0] mem_data_q;
  logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]             count_q, count_d;

  // Storage is deliberately left out of reset; only pointers and count matter.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_addr_q[wr_ptr_q] <= push_addr_i;
      mem_data_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_addr_o = mem_addr_q[rd_ptr_q];
  assign head_data_o = mem_data_q[rd_ptr_q];
  assign count_o     = count_q;

`ifdef RF_WB_FORWARD_EN
  assign mem_addr_o = mem_addr_q;
  assign mem_data_o = mem_data_q;
  assign rd_ptr_o   = rd_ptr_q;
`endif
endmodule

// File: rtl/rf_write_buffer.sv
// rtl/rf_write_buffer.sv - buffered register-file write port with one-per-cycle drain register
// Read forwarding from pending writes is built only when RF_WB_FORWARD_EN is defined.
module rf_write_buffer
  import rf_pkg::*;
#(
  parameter int DEPTH  = RF_WB_DEPTH,
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ADDR_W-1:0]      in_addr,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   flush,
  output logic [ADDR_W-1:0]      rf_wAddr,
  output logic [DATA_W-1:0]      rf_wData,
  output logic                   rf_we,
  output logic [$clog2(DEPTH):0] count,
  input  logic [ADDR_W-1:0]      rd_addr,
  input  logic [DATA_W-1:0]      rf_rData,
  output logic [DATA_W-1:0]      rd_data
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic              fifo_push, fifo_pop;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_wAddr_q, rf_wAddr_d;
  logic [DATA_W-1:0] rf_wData_q, rf_wData_d;

`ifdef RF_WB_FORWARD_EN
  logic [DEPTH-1:0][ADDR_W-1:0] mem_addr;
  logic [DEPTH-1:0][DATA_W-1:0] mem_data;
  logic [PTR_W-1:0]             rd_ptr;
  logic [PTR_W-1:0]             fwd_idx;
  logic [DATA_W-1:0]            fwd_data;
`endif

  // A full buffer refuses even when the head drains this cycle.
  assign in_ready  = !reset && !flush && (count < CNT_W'(DEPTH));
  assign fifo_push = in_valid && in_ready;
  assign fifo_pop  = (count != '0) && !flush;

  rf_wb_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (fifo_push),
    .pop_i       (fifo_pop),
    .flush_i     (flush),
    .push_addr_i (in_addr),
    .push_data_i (in_data),
    .head_addr_o (head_addr),
    .head_data_o (head_data),
    .count_o     (count)
`ifdef RF_WB_FORWARD_EN
    ,
    .mem_addr_o  (mem_addr),
    .mem_data_o  (mem_data),
    .rd_ptr_o    (rd_ptr)
`endif
  );

  always_comb begin
    rf_we_d    = fifo_pop;
    rf_wAddr_d = rf_wAddr_q;
    rf_wData_d = rf_wData_q;
    if (fifo_pop) begin
      rf_wAddr_d = head_addr;
      rf_wData_d = head_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_we_q    <= 1'b0;
      rf_wAddr_q <= '0;
      rf_wData_q <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_wAddr_q <= rf_wAddr_d;
      rf_wData_q <= rf_wData_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_wAddr = rf_wAddr_q;
  assign rf_wData = rf_wData_q;

`ifdef RF_WB_FORWARD_EN
  // Scan oldest to newest so the youngest match overrides; drain register is oldest of all.
  always_comb begin
    fwd_data = rf_rData;
    fwd_idx  = rd_ptr;
    if (rf_we_q && (rf_wAddr_q == rd_addr)) fwd_data = rf_wData_q;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) && (mem_addr[fwd_idx] == rd_addr)) fwd_data = mem_data[fwd_idx];
    end
  end

  assign rd_data = fwd_data;
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^rd_addr;
  assign rd_data        = rf_rData;
`endif
endmodule
